// File: rtl/seq_adder.sv
// ---------------------------------------------------------------------------
// seq_adder
//
// This block is a multi-cycle ripple adder and subtractor. Each clock it adds
// one DIGIT-bit slice of the operand pair. The carry between slices is kept
// in a register, so the design needs no WIDTH-bit combinational carry chain.
// A result takes STEPS = WIDTH/DIGIT cycles in RUN. The result is then held
// in DONE until the sink takes it.
//
// Subtraction is computed as a + ~b + ~cin:
//    a - b - cin = a + (2^WIDTH - 1 - b) + (1 - cin) - 2^WIDTH
// The raw carry-out is therefore the inverse of the borrow-out. The signed
// overflow flag is the same for both operations: carry into the MSB XOR carry
// out of the MSB.
//
// Parameters:
//    WIDTH      operand/result width (multiple of DIGIT)
//    DIGIT      bits added per clock (1 .. WIDTH)
//
// Ports:
//    clk        rising-edge clock
//    rst_n      synchronous active-low reset
//    in_valid   operand set present            (source -> adder)
//    in_ready   adder can accept operands      (adder -> source), high in IDLE
//    a, b       operands
//    cin        carry-in (add) / borrow-in (subtract)
//    sub        0 = add, 1 = subtract
//    out_valid  result present                 (adder -> sink), high in DONE
//    out_ready  sink accepts result            (sink -> adder)
//    sum        result, held from DONE until the next DONE
//    cout       carry-out (add) / borrow-out (subtract)
//    ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module seq_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   // The counter keeps at least one bit so that STEPS = 1 still elaborates.
   localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

   // Stop elaboration on an illegal WIDTH/DIGIT pairing.
   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_guard
      $error("seq_adder: WIDTH must be a non-zero multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   // Operands are consumed from the LSB end. Both operand registers shift
   // right by one digit per RUN cycle, so the active digit is always at
   // bit 0. This avoids a WIDTH-wide digit-select mux.
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;         // already inverted for subtract
   logic             r_sub;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;       // result under construction
   logic [WIDTH-1:0] r_sum;       // published result
   logic             r_cout;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic [DIGIT-1:0] w_a_dig;
   logic [DIGIT-1:0] w_b_dig;
   logic [DIGIT:0]   w_dsum;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_raw_c;
   logic             w_c_msb_in;

   assign w_a_dig = r_a[DIGIT-1:0];
   assign w_b_dig = r_b[DIGIT-1:0];

   // One digit of the ripple: a_digit + b'_digit + carry, with a spare bit
   // that carries out to the next digit.
   assign w_dsum = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};

   // The accumulator shifts right, and each new digit enters at the top.
   // After STEPS digits the first digit has reached bit 0.
   assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

   // On the last digit, the carry into the MSB is recovered from the MSB sum
   // bit. Since s = a ^ b ^ c_in, we have c_in = s ^ a ^ b. This stays valid
   // when DIGIT = 1.
   assign w_raw_c    = w_dsum[DIGIT];
   assign w_c_msb_in = w_dsum[DIGIT-1] ^ w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1];

   // Control state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode. in_ready and out_valid come straight
   // from the state register, so they hold steady for the whole cycle.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            w_last = (r_cnt == LAST_CNT);
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, ripple one digit per RUN cycle, and
   // publish the result and flags on the last digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= {WIDTH{1'b0}};
         r_b     <= {WIDTH{1'b0}};
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= {CW{1'b0}};
         r_acc   <= {WIDTH{1'b0}};
         r_sum   <= {WIDTH{1'b0}};
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_sub   <= sub;
                  r_carry <= sub ? ~cin : cin;
                  r_cnt   <= {CW{1'b0}};
                  r_acc   <= {WIDTH{1'b0}};
               end
            end
            S_RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_acc   <= w_acc_nxt;
               r_carry <= w_raw_c;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_sum  <= w_acc_nxt;
                  // For subtract, the borrow is the inverted raw carry.
                  r_cout <= r_sub ^ w_raw_c;
                  r_ovf  <= w_c_msb_in ^ w_raw_c;
               end
            end
            default: begin
               // DONE: everything holds while the sink decides.
            end
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_adder
//
// Five seq_adder instances share one clock and reset:
//    index 0: (8,2)   1: (8,1)   2: (8,8)   3: (16,4)   4: (32,8)
// Each scenario task drives one instance and checks it against constants or
// against ref_model. ref_model works from the arithmetic definition, using
// signed/unsigned integer math.
// ---------------------------------------------------------------------------
module tb_seq_adder;

   localparam int NI = 5;

   function automatic int cfg_w(input int g);
      case (g)
         3:       return 16;
         4:       return 32;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_d(input int g);
      case (g)
         0:       return 2;
         1:       return 1;
         2:       return 8;
         3:       return 4;
         default: return 8;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv    [NI];
   logic        orr   [NI];
   logic        cin_v [NI];
   logic        sub_v [NI];
   logic [31:0] a_v   [NI];
   logic [31:0] b_v   [NI];
   logic        ir    [NI];
   logic        ov_v  [NI];
   logic        co_v  [NI];
   logic        of_v  [NI];
   logic [31:0] s_v   [NI];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = cfg_w(g);
      localparam int D = cfg_d(g);
      logic         w_ir;
      logic         w_ov;
      logic         w_co;
      logic         w_of;
      logic [W-1:0] w_s;

      seq_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[g]),
         .in_ready  (w_ir),
         .a         (a_v[g][W-1:0]),
         .b         (b_v[g][W-1:0]),
         .cin       (cin_v[g]),
         .sub       (sub_v[g]),
         .out_valid (w_ov),
         .out_ready (orr[g]),
         .sum       (w_s),
         .cout      (w_co),
         .ovf       (w_of)
      );

      assign ir[g]   = w_ir;
      assign ov_v[g] = w_ov;
      assign co_v[g] = w_co;
      assign of_v[g] = w_of;
      assign s_v[g]  = 32'(w_s);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arithmetic on w-bit operands.
   function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub,
                                     output logic [31:0] s, output logic co, output logic ovf);
      longint m, half, ua, ub, sa, sb, r, sr, c;
      m    = longint'(1) << w;
      half = m / 2;
      ua   = longint'(a) & (m - 1);
      ub   = longint'(b) & (m - 1);
      sa   = (ua >= half) ? ua - m : ua;
      sb   = (ub >= half) ? ub - m : ub;
      c    = longint'(cin);
      if (!sub) begin
         r  = ua + ub + c;
         co = (r >= m);
         sr = sa + sb + c;
      end else begin
         r  = ua - ub - c;
         co = (ua < ub + c);
         sr = sa - sb - c;
      end
      s   = 32'(r & (m - 1));
      ovf = (sr >= half) || (sr < -half);
   endfunction

   function automatic logic [31:0] wmask(input int w);
      return 32'((longint'(1) << w) - 1);
   endfunction

   // Run one operation on instance g. The task waits for in_ready, then
   // accepts the operands. It measures the latency to out_valid, holds
   // out_ready low for bp cycles, and then releases the result.
   task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input int gap, input int bp,
                         input bit scribble,
                         output logic [31:0] rs, output logic rc, output logic ro,
                         output int lat, output bit held, output bit rel_ok, output bit to);
      int n;
      to   = 1'b0;
      held = 1'b1;
      iv[g] = 1'b0;
      for (int i = 0; i < gap; i++) begin
         orr[g] = 1'($urandom_range(0, 1));
         tick();
      end
      orr[g]   = 1'b0;
      a_v[g]   = a;
      b_v[g]   = b;
      cin_v[g] = cin;
      sub_v[g] = sub;
      iv[g]    = 1'b1;
      n = 0;
      while (ir[g] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (ir[g] !== 1'b1) to = 1'b1;
      tick();                                   // acceptance edge
      iv[g] = 1'b0;
      lat = 0;
      while (ov_v[g] !== 1'b1 && lat < 200) begin
         orr[g] = 1'($urandom_range(0, 1));
         if (scribble) begin
            a_v[g]   = $urandom();
            b_v[g]   = $urandom();
            cin_v[g] = 1'($urandom_range(0, 1));
            sub_v[g] = 1'($urandom_range(0, 1));
            iv[g]    = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
      end
      iv[g]  = 1'b0;
      orr[g] = 1'b0;
      if (ov_v[g] !== 1'b1) to = 1'b1;
      rs = s_v[g];
      rc = co_v[g];
      ro = of_v[g];
      for (int i = 0; i < bp; i++) begin
         tick();
         if (ov_v[g] !== 1'b1 || s_v[g] !== rs || co_v[g] !== rc || of_v[g] !== ro || ir[g] !== 1'b0)
            held = 1'b0;
      end
      orr[g] = 1'b1;
      tick();
      orr[g] = 1'b0;
      rel_ok = (ov_v[g] === 1'b0) && (ir[g] === 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int g = 0; g < NI; g++) begin
         n_total++;
         if (ir[g] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b want 1", g, ir[g]);
         else n_pass++;
         n_total++;
         if (ov_v[g] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", g, ov_v[g]);
         else n_pass++;
         n_total++;
         if ({s_v[g], co_v[g], of_v[g]} !== 34'd0)
            $display("FAIL reset_outputs[%0d]: sum=%h cout=%b ovf=%b want 0", g, s_v[g], co_v[g], of_v[g]);
         else n_pass++;
      end
   endtask

   task automatic test_directed();
      logic [7:0] ta [5] = '{8'hFF, 8'h7F, 8'h10, 8'h05, 8'h80};
      logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h20, 8'h07, 8'h01};
      logic       tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       tsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] es [5] = '{8'h00, 8'h80, 8'h31, 8'hFE, 8'h7F};
      logic       ec [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] rs;
      logic rc, ro;
      int lat;
      bit held, rel, to;
      for (int i = 0; i < 5; i++) begin
         run_op(0, 32'(ta[i]), 32'(tb[i]), tc[i], tsb[i], 1, 0, 1'b0, rs, rc, ro, lat, held, rel, to);
         n_total++;
         if (to || lat != 4) $display("FAIL directed_latency[%0d]: got %0d timeout=%0d want 4", i, lat, to);
         else n_pass++;
         n_total++;
         if (rs !== 32'(es[i])) $display("FAIL directed_sum[%0d]: got %h want %h", i, rs, es[i]);
         else n_pass++;
         n_total++;
         if (rc !== ec[i] || ro !== eo[i])
            $display("FAIL directed_flags[%0d]: cout=%b ovf=%b want %b %b", i, rc, ro, ec[i], eo[i]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int n;
      a_v[0] = 32'h7F; b_v[0] = 32'h01; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
      orr[0] = 1'b0;
      iv[0]  = 1'b1;                            // left high: ignored in RUN/DONE
      tick();                                   // accept
      n = 0;
      while (ov_v[0] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      n_total++;
      if (n != 4) $display("FAIL bp_latency: got %0d want 4", n);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (ov_v[0] !== 1'b1 || s_v[0] !== 32'h80 || co_v[0] !== 1'b0 || of_v[0] !== 1'b1 || ir[0] !== 1'b0)
            $display("FAIL bp_hold[%0d]: valid=%b sum=%h cout=%b ovf=%b rdy=%b want 1 80 0 1 0",
                     i, ov_v[0], s_v[0], co_v[0], of_v[0], ir[0]);
         else n_pass++;
      end
      orr[0] = 1'b1;
      tick();                                   // release edge, in_valid still high
      iv[0]  = 1'b0;
      orr[0] = 1'b0;
      n_total++;
      if (ov_v[0] !== 1'b0 || ir[0] !== 1'b1)
         $display("FAIL bp_release: valid=%b in_ready=%b want 0 1", ov_v[0], ir[0]);
      else n_pass++;
      n_total++;
      if (s_v[0] !== 32'h80 || co_v[0] !== 1'b0 || of_v[0] !== 1'b1)
         $display("FAIL bp_keep_after_release: sum=%h cout=%b ovf=%b want 80 0 1", s_v[0], co_v[0], of_v[0]);
      else n_pass++;
      tick();
      n_total++;
      if (ir[0] !== 1'b1) $display("FAIL bp_no_accept: in_ready=%b want 1", ir[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      a_v[0] = 32'h12; b_v[0] = 32'h34; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
      iv[0] = 1'b1;
      tick();                                   // accept at edge k
      iv[0] = 1'b0;
      orr[0] = 1'b1;
      tick();                                   // k+1
      rst_n = 1'b0;
      tick();                                   // k+2 reset edge
      rst_n = 1'b1;
      n_total++;
      if (ov_v[0] !== 1'b0 || ir[0] !== 1'b1)
         $display("FAIL midrun_state: valid=%b in_ready=%b want 0 1", ov_v[0], ir[0]);
      else n_pass++;
      n_total++;
      if (s_v[0] !== 32'h0 || co_v[0] !== 1'b0 || of_v[0] !== 1'b0)
         $display("FAIL midrun_outputs: sum=%h cout=%b ovf=%b want 0", s_v[0], co_v[0], of_v[0]);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ov_v[0] !== 1'b0) seen = 1'b1;
      end
      orr[0] = 1'b0;
      n_total++;
      if (seen) $display("FAIL midrun_no_result: got out_valid=1 want 0");
      else n_pass++;
   endtask

   task automatic test_input_change();
      logic [31:0] a, b, rs, es;
      logic cin, sub, rc, ro, ec, eo;
      int lat, g, w;
      bit held, rel, to;
      for (int i = 0; i < 40; i++) begin
         g   = (i % 2 == 0) ? 0 : 3;
         w   = cfg_w(g);
         a   = $urandom() & wmask(w);
         b   = $urandom() & wmask(w);
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         ref_model(w, a, b, cin, sub, es, ec, eo);
         run_op(g, a, b, cin, sub, 0, 1, 1'b1, rs, rc, ro, lat, held, rel, to);
         n_total++;
         if (to || rs !== es || rc !== ec || ro !== eo)
            $display("FAIL input_change[%0d]: a=%h b=%h cin=%b sub=%b got %h/%b/%b want %h/%b/%b",
                     i, a, b, cin, sub, rs, rc, ro, es, ec, eo);
         else n_pass++;
      end
   endtask

   task automatic test_sweep(input int g, input int nops);
      logic [31:0] a, b, rs, es, m;
      logic cin, sub, rc, ro, ec, eo;
      int lat, w, steps;
      bit held, rel, to;
      w     = cfg_w(g);
      steps = cfg_w(g) / cfg_d(g);
      m     = wmask(w);
      for (int i = 0; i < nops; i++) begin
         a = $urandom() & m;
         b = $urandom() & m;
         // Mix in edge operands: 0, all-ones, most-negative, most-positive.
         case ($urandom_range(0, 7))
            0: a = 32'd0;
            1: a = m;
            2: b = m;
            3: b = (m >> 1) + 32'd1;
            4: a = m >> 1;
            default: ;
         endcase
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         ref_model(w, a, b, cin, sub, es, ec, eo);
         run_op(g, a, b, cin, sub, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0,
                rs, rc, ro, lat, held, rel, to);
         n_total++;
         if (to || lat != steps)
            $display("FAIL sweep%0d_latency[%0d]: got %0d timeout=%0d want %0d", g, i, lat, to, steps);
         else n_pass++;
         n_total++;
         if (rs !== es || rc !== ec || ro !== eo)
            $display("FAIL sweep%0d_result[%0d]: a=%h b=%h cin=%b sub=%b got %h/%b/%b want %h/%b/%b",
                     g, i, a, b, cin, sub, rs, rc, ro, es, ec, eo);
         else n_pass++;
         n_total++;
         if (!held || !rel)
            $display("FAIL sweep%0d_handshake[%0d]: held=%0d released=%0d want 1 1", g, i, held, rel);
         else n_pass++;
      end
   endtask

   initial begin
      for (int g = 0; g < NI; g++) begin
         iv[g] = 1'b0; orr[g] = 1'b0; cin_v[g] = 1'b0; sub_v[g] = 1'b0;
         a_v[g] = 32'd0; b_v[g] = 32'd0;
      end
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_input_change();
      for (int g = 0; g < NI; g++) test_sweep(g, 1000);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
